// File: rtl/lcd_bus_arbiter_if.sv
// Requester-side handshake and LCD pin bundle for lcd_bus_arbiter.
// The arbiter uses the slave modport; requesters and the LCD side see the master view.
interface lcd_bus_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   rs_in;
    logic [8*NUM_REQ-1:0] data_in;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   ack;
    logic                 busy;
    logic [7:0]           LCD_DATA;
    logic                 LCD_RS;
    logic                 LCD_EN;
    logic                 LCD_RW;

    modport master (
        output req, rs_in, data_in,
        input  gnt, ack, busy, LCD_DATA, LCD_RS, LCD_EN, LCD_RW
    );

    modport slave (
        input  req, rs_in, data_in,
        output gnt, ack, busy, LCD_DATA, LCD_RS, LCD_EN, LCD_RW
    );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// Shares one HD44780 write bus between NUM_REQ requesters and runs the full write cycle.
// Define LCD_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module lcd_bus_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 25,
    parameter int HOLD_CYC  = 2,
    parameter int DATA_WAIT = 2000,
    parameter int CMD_WAIT  = 82000
) (
    input logic              CLOCK_50,
    input logic              reset,
    lcd_bus_arbiter_if.slave bus
);
    localparam int MAXW = (CMD_WAIT > DATA_WAIT) ? CMD_WAIT : DATA_WAIT;
    localparam int CW   = ($clog2(MAXW + 1) > 17) ? $clog2(MAXW + 1) : 17;
    localparam int PW   = $clog2(NUM_REQ);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] ENABLE = 3'd2;
    localparam logic [2:0] HOLD   = 3'd3;
    localparam logic [2:0] WAIT   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic [2:0]         state;
    logic [CW-1:0]      cnt;
    logic [PW-1:0]      owner;
    logic [PW-1:0]      ptr;
    logic [NUM_REQ-1:0] gnt_r;
    logic [NUM_REQ-1:0] ack_r;
    logic               en_r;
    logic               rs_l;
    logic [7:0]         data_l;

    logic               any_req;
    logic [PW-1:0]      win;
    int                 idx;
    logic               long_cmd;

    // Scan from the far end so the last hit is the first requester at/after ptr.
    always_comb begin
        any_req = 1'b0;
        win     = '0;
        idx     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (bus.req[idx]) begin
                any_req = 1'b1;
                win     = PW'(idx);
            end
        end
    end

    // Clear display and return home need the long execution wait.
    assign long_cmd = !rs_l && (data_l[7:2] == 6'd0);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            owner  <= '0;
            ptr    <= '0;
            gnt_r  <= '0;
            ack_r  <= '0;
            en_r   <= 1'b0;
            rs_l   <= 1'b0;
            data_l <= 8'h00;
        end else begin
            ack_r <= '0;
            case (state)
                IDLE: if (any_req) begin
                    state  <= SETUP;
                    cnt    <= CW'(SETUP_CYC - 1);
                    owner  <= win;
                    gnt_r  <= NUM_REQ'(1) << win;
                    rs_l   <= bus.rs_in[win];
                    data_l <= bus.data_in[win*8 +: 8];
                end
                SETUP: if (cnt == '0) begin
                    state <= ENABLE;
                    cnt   <= CW'(EN_CYC - 1);
                    en_r  <= 1'b1;
                end else cnt <= cnt - 1'b1;
                ENABLE: if (cnt == '0) begin
                    state <= HOLD;
                    cnt   <= CW'(HOLD_CYC - 1);
                    en_r  <= 1'b0;
                end else cnt <= cnt - 1'b1;
                HOLD: if (cnt == '0) begin
                    state <= WAIT;
                    cnt   <= long_cmd ? CW'(CMD_WAIT - 1) : CW'(DATA_WAIT - 1);
                end else cnt <= cnt - 1'b1;
                WAIT: if (cnt == '0) begin
                    state <= DONE;
                    ack_r <= NUM_REQ'(1) << owner;
                end else cnt <= cnt - 1'b1;
                DONE: begin
                    state <= IDLE;
                    gnt_r <= '0;
`ifdef LCD_ARB_FIXED_PRIO_EN
                    ptr   <= '0;
`else
                    ptr   <= (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt      = gnt_r;
    assign bus.ack      = ack_r;
    assign bus.busy     = (state != IDLE);
    assign bus.LCD_EN   = en_r;
    assign bus.LCD_RS   = rs_l;
    assign bus.LCD_DATA = data_l;
    assign bus.LCD_RW   = 1'b0;
endmodule
